// File: rtl/tick_stretcher.sv
// Stretches single-cycle event ticks into visible pulses with a minimum low gap.
// Optional macro TICK_STRETCHER_RETRIGGER_EN: a tick during a pulse restarts its high time.
module tick_stretcher #(
  parameter int unsigned SYS_FREQ  = 100_000_000,
  parameter int unsigned ON_TIME   = 50,
  parameter int unsigned OFF_TIME  = 50,
  parameter int unsigned TIME_BASE = 1000,
  parameter int unsigned PEND_MAX  = 15,
  localparam int unsigned PW       = $clog2(PEND_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_in,
  output logic          pulse_out,
  output logic          busy,
  output logic [PW-1:0] pend_cnt,
  output logic          overflow
);

  localparam int unsigned ON_CYC  = SYS_FREQ / TIME_BASE * ON_TIME;
  localparam int unsigned OFF_CYC = SYS_FREQ / TIME_BASE * OFF_TIME;
  localparam int unsigned MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  generate
    if (ON_CYC < 1 || OFF_CYC < 1) begin : g_bad_timing
      $error("tick_stretcher: ON_CYC and OFF_CYC must both be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          pulse_q, pulse_d;
  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic          queue_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state; ticks not consumed by a pulse start fall through to the queue.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pend_d     = pend_q;
    ovf_d      = 1'b0;
    queue_tick = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick_in) begin
          state_d = ST_ON;
          timer_d = '0;
        end
      end
      ST_ON: begin
`ifdef TICK_STRETCHER_RETRIGGER_EN
        if (tick_in) begin
          timer_d = '0;
        end else if (timer_q == TW'(ON_CYC - 1)) begin
          state_d = ST_GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`else
        queue_tick = tick_in;
        if (timer_q == TW'(ON_CYC - 1)) begin
          state_d = ST_GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      ST_GAP: begin
        if (timer_q == TW'(OFF_CYC - 1)) begin
          timer_d = '0;
          if (pend_q != '0) begin
            state_d    = ST_ON;
            pend_d     = pend_q - PW'(1);
            queue_tick = tick_in;
          end else if (tick_in) begin
            state_d = ST_ON;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d    = timer_q + TW'(1);
          queue_tick = tick_in;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // A decrement in the same cycle always leaves room, so no overflow then.
    if (queue_tick) begin
      if (pend_d < PW'(PEND_MAX)) begin
        pend_d = pend_d + PW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign pulse_d = (state_d == ST_ON);
  assign busy_d  = (state_d != ST_IDLE);

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign pend_cnt  = pend_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/tick_stretcher.md
Name: tick_stretcher

Overview:
Output-side counterpart of the input debouncer. Converts single-cycle event ticks (UART rx-done, debounced button tick, error strobes) into human-visible pulses on an LED or indicator pin. Each tick gives a pulse of guaranteed minimum high time followed by a guaranteed minimum low gap. Ticks arriving while busy are queued in a saturating counter, so every event stays visible up to the queue limit.

Parameters:
SYS_FREQ, 100_000_000, clock frequency in Hz
ON_TIME, 50, pulse high duration in TIME_BASE units
OFF_TIME, 50, minimum low gap after each pulse in TIME_BASE units
TIME_BASE, 1000, time unit divisor; 1000 = ms, 1_000_000 = us
PEND_MAX, 15, maximum queued ticks; pend_cnt width PW = $clog2(PEND_MAX+1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
tick_in  input  1  event strobe; each high cycle counts as one tick
pulse_out  output  1  stretched pulse, registered
busy  output  1  high whenever state != IDLE, registered
pend_cnt  output  PW  number of queued ticks not yet shown
overflow  output  1  one-cycle strobe when a tick is dropped because the queue is full

Behaviour:
- Derived constants: ON_CYC = SYS_FREQ/TIME_BASE*ON_TIME and OFF_CYC = SYS_FREQ/TIME_BASE*OFF_TIME. Both must be >= 1; elaboration error otherwise. Timer width = $clog2(max(ON_CYC,OFF_CYC)).
- Reset (sync, rst=1 at edge): state=IDLE, timer=0, pulse_out=0, busy=0, pend_cnt=0, overflow=0. Reset mid-pulse aborts it at that edge and discards the queue. A tick_in in the reset cycle is ignored.
- States: IDLE, ON, GAP.
- IDLE with tick_in=1 at edge n:
  - state=ON, timer=0, pulse_out=1 from cycle n+1. Latency 1 cycle.
  - The tick is consumed directly; pend_cnt is unchanged.
- ON:
  - Timer increments each cycle.
  - When timer==ON_CYC-1: state=GAP, timer=0, pulse_out=0.
  - pulse_out is high for exactly ON_CYC cycles, i.e. cycles n+1..n+ON_CYC.
- GAP:
  - Timer increments each cycle.
  - When timer==OFF_CYC-1:
    - If pend_cnt>0: state=ON, pend_cnt-1.
    - Else if tick_in=1: state=ON, tick consumed directly.
    - Else: state=IDLE.
  - pulse_out is low for exactly OFF_CYC cycles between pulses.
- Queueing: tick_in=1 in ON or GAP that is not consumed at the GAP end:
  - pend_cnt+1 if pend_cnt<PEND_MAX.
  - Otherwise the tick is dropped and overflow=1 for the following cycle.
- Simultaneous events at GAP end with pend_cnt>0 and tick_in=1: net pend_cnt unchanged, no overflow (even at PEND_MAX).
- overflow is a registered strobe; it is 0 in every cycle without a dropped tick.
- A tick_in held high for k cycles counts as k ticks; callers drive single-cycle strobes.
- No wrap-around anywhere: timer resets on state change, pend_cnt saturates.

Optional Feature:
TICK_STRETCHER_RETRIGGER_EN
- Defined:
  - tick_in=1 in ON at edge n resets timer to 0, so pulse_out stays high through cycle n+ON_CYC.
  - That tick is absorbed and not queued.
  - Ticks in GAP queue as normal.
- Undefined: ticks in ON queue exactly as described above.

Test Plan:
Bench params: SYS_FREQ=1000, TIME_BASE=1000, ON_TIME=4, OFF_TIME=3, PEND_MAX=3 (so ON_CYC=4, OFF_CYC=3).
1. Single tick at cycle 10 -> pulse_out=1 cycles 11-14, 0 from 15; busy=1 cycles 11-17; IDLE at 18; pend_cnt=0 throughout.
2. Ticks at cycles 10,11,12 -> pend_cnt 1 at 12, 2 at 13. Pulses high 11-14, 18-21, 25-28. pend_cnt drops to 1 at 18 and 0 at 25. busy falls at 32.
3. Ticks on cycles 11-15 (5 ticks during ON, after an initial tick at 10) -> pend_cnt saturates at 3. overflow=1 at cycles 15 and 16. Exactly 4 pulses total.
4. Tick at cycle 17 (last GAP cycle) with pend_cnt=0, after tick at 10 -> pulse_out=1 cycles 18-21 with no IDLE cycle; pend_cnt stays 0.
5. rst=1 at cycle 12 during ON with pend_cnt=2 -> at 13: pulse_out=0, busy=0, pend_cnt=0. A tick at 20 gives a normal pulse 21-24.
6. With TICK_STRETCHER_RETRIGGER_EN: ticks at 10 and 13 -> pulse_out=1 cycles 11-17, 0 at 18, pend_cnt=0. Without the macro: pulses 11-14 and 18-21.
